// File: rtl/btb_sa_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : btb_sa_ctr                                                |
// | Purpose  : Set-associative tagged branch target buffer with a 2-bit  |
// |            taken counter per entry, registered lookup, EX update     |
// |            port with round-robin allocation and a clearing sweep.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module btb_sa_ctr #(
  parameter int NUM_SETS    = 64,
  parameter int NUM_WAYS    = 4,
  parameter int TAG_BITS    = 8,
  parameter int TARGET_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  output logic                   ready,
  input  logic                   req_valid,
  input  logic [31:0]            req_pc,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   resp_taken,
  output logic [TARGET_BITS-1:0] resp_target,
  input  logic                   upd_valid,
  input  logic [31:0]            upd_pc,
  input  logic                   upd_taken,
  input  logic [TARGET_BITS-1:0] upd_target
);

  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [0:0] c_st_sweep = 1'b0;
  localparam logic [0:0] c_st_idle  = 1'b1;

  // Entry storage; only valid, ctr and rr need clearing, which the sweep does.
  logic [NUM_WAYS-1:0]    r_valid  [NUM_SETS];
  logic [TAG_BITS-1:0]    r_tag    [NUM_SETS][NUM_WAYS];
  logic [TARGET_BITS-1:0] r_target [NUM_SETS][NUM_WAYS];
  logic [1:0]             r_ctr    [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0]    r_rr     [NUM_SETS];

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [INDEX_BITS-1:0] r_sweep_idx;
  logic                  w_sweep_en;
  logic                  w_sweep_last;

  logic [INDEX_BITS-1:0] w_req_idx;
  logic [TAG_BITS-1:0]   w_req_tag;
  logic                  w_req_acc;
  logic                  w_req_hit;
  logic [WAY_BITS-1:0]   w_req_way;

  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_upd_en;
  logic                  w_upd_hit;
  logic [WAY_BITS-1:0]   w_upd_way;
  logic [1:0]            w_ctr_cur;
  logic [1:0]            w_ctr_next;
  logic [WAY_BITS-1:0]   w_rr_cur;
  logic [WAY_BITS-1:0]   w_rr_next;

  // Bits of the PCs outside the index/tag fields are deliberately ignored.
  logic w_unused_bits;
  assign w_unused_bits = ^{req_pc, upd_pc};

  assign w_req_idx = req_pc[INDEX_BITS+1:2];
  assign w_req_tag = req_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_upd_idx = upd_pc[INDEX_BITS+1:2];
  assign w_upd_tag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  assign w_req_acc    = req_valid && ready;
  // A flush in the same cycle wins over the update.
  assign w_upd_en     = upd_valid && ready && !flush;
  assign w_sweep_last = (r_sweep_idx == INDEX_BITS'(NUM_SETS - 1));

  // State register: reset always restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_sweep;
    else     r_state <= w_state_next;
  end

  // Next-state logic: sweep until the last set is cleared, flush restarts it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_sweep: if (!flush && w_sweep_last) w_state_next = c_st_idle;
      c_st_idle:  if (flush) w_state_next = c_st_sweep;
      default:    w_state_next = c_st_sweep;
    endcase
  end

  // FSM outputs: accept traffic only when idle, clear one set per sweep cycle.
  always_comb begin
    ready      = (r_state == c_st_idle);
    w_sweep_en = (r_state == c_st_sweep);
  end

  // Sweep set pointer; wraps to 0 naturally after the last set.
  always_ff @(posedge clk) begin
    if (rst || flush)    r_sweep_idx <= '0;
    else if (w_sweep_en) r_sweep_idx <= r_sweep_idx + INDEX_BITS'(1);
  end

  // Lookup tag compare; scanning downwards lets the lowest matching way win.
  always_comb begin
    w_req_hit = 1'b0;
    w_req_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_req_idx][w] && (r_tag[w_req_idx][w] == w_req_tag)) begin
        w_req_hit = 1'b1;
        w_req_way = WAY_BITS'(w);
      end
    end
  end

  // Update tag compare and saturating counter step for the hit way.
  always_comb begin
    w_upd_hit = 1'b0;
    w_upd_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_upd_idx][w] && (r_tag[w_upd_idx][w] == w_upd_tag)) begin
        w_upd_hit = 1'b1;
        w_upd_way = WAY_BITS'(w);
      end
    end
    w_ctr_cur = r_ctr[w_upd_idx][w_upd_way];
    w_rr_cur  = r_rr[w_upd_idx];
    if (upd_taken) w_ctr_next = (w_ctr_cur == 2'd3) ? 2'd3 : w_ctr_cur + 2'd1;
    else           w_ctr_next = (w_ctr_cur == 2'd0) ? 2'd0 : w_ctr_cur - 2'd1;
  end

  // Round-robin advance; a single-way set keeps its pointer at 0.
  generate
    if (NUM_WAYS == 1) begin : g_rr_single
      assign w_rr_next = '0;
    end else begin : g_rr_multi
      assign w_rr_next = w_rr_cur + WAY_BITS'(1);
    end
  endgenerate

  // Storage writes: sweep clears a set, otherwise apply an accepted update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_sweep_en) begin
        r_valid[r_sweep_idx] <= '0;
        r_rr[r_sweep_idx]    <= '0;
        for (int w = 0; w < NUM_WAYS; w++) r_ctr[r_sweep_idx][w] <= 2'b00;
      end else if (w_upd_en) begin
        if (w_upd_hit) begin
          r_ctr[w_upd_idx][w_upd_way] <= w_ctr_next;
          if (upd_taken) r_target[w_upd_idx][w_upd_way] <= upd_target;
        end else if (upd_taken) begin
          r_valid[w_upd_idx][w_rr_cur]  <= 1'b1;
          r_tag[w_upd_idx][w_rr_cur]    <= w_upd_tag;
          r_target[w_upd_idx][w_rr_cur] <= upd_target;
          r_ctr[w_upd_idx][w_rr_cur]    <= 2'b10;
          r_rr[w_upd_idx]               <= w_rr_next;
        end
      end
    end
  end

  // Registered response, read from the contents before any same-edge update.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_taken  <= 1'b0;
      resp_target <= '0;
    end else begin
      resp_valid  <= w_req_acc;
      resp_hit    <= w_req_acc && w_req_hit;
      resp_taken  <= w_req_acc && w_req_hit && r_ctr[w_req_idx][w_req_way][1];
      resp_target <= (w_req_acc && w_req_hit) ? r_target[w_req_idx][w_req_way] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_sa_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_btb_sa_ctr                                             |
// | Purpose  : Directed self-checking bench for btb_sa_ctr with a        |
// |            behavioural reference model and literal expectations.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_btb_sa_ctr;

  localparam int NS = 64;
  localparam int NW = 4;
  localparam int IB = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        ready, resp_valid, resp_hit, resp_taken;
  logic [31:0] resp_target;

  int n_checks = 0;
  int n_fail   = 0;

  btb_sa_ctr dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready),
    .req_valid(req_valid), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_taken(resp_taken),
    .resp_target(resp_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table of entries, per-set round-robin, sweep countdown.
  bit          mv   [NS][NW];
  int          mtag [NS][NW];
  logic [31:0] mtgt [NS][NW];
  int          mctr [NS][NW];
  int          mrr  [NS];
  int          m_sweep_left = 0;
  bit          m_known = 1'b0;
  bit          e_rv, e_hit, e_tk;
  logic [31:0] e_tg;

  function automatic void model_clear();
    for (int s = 0; s < NS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        mv[s][w]   = 1'b0;
        mctr[s][w] = 0;
      end
    end
  endfunction

  function automatic int pc_set(input logic [31:0] pc);
    return int'(pc / 4) % NS;
  endfunction

  function automatic int pc_tag(input logic [31:0] pc);
    return int'(pc / (4 * NS)) % 256;
  endfunction

  function automatic int find_way(input int s, input int t);
    for (int w = 0; w < NW; w++) if (mv[s][w] && mtag[s][w] == t) return w;
    return -1;
  endfunction

  // Compare process: advance the model on every edge, check outputs just after.
  always @(posedge clk) begin : cmp
    int s, t, w;
    if (rst) begin
      m_known = 1'b1;
      m_sweep_left = NS;
      model_clear();
      e_rv = 0; e_hit = 0; e_tk = 0; e_tg = '0;
    end else if (m_known) begin
      e_rv = req_valid && (m_sweep_left == 0);
      e_hit = 0; e_tk = 0; e_tg = '0;
      if (e_rv) begin
        s = pc_set(req_pc);
        w = find_way(s, pc_tag(req_pc));
        if (w >= 0) begin
          e_hit = 1;
          e_tk  = (mctr[s][w] >= 2);
          e_tg  = mtgt[s][w];
        end
      end
      if (flush) begin
        m_sweep_left = NS;
        model_clear();
      end else if (m_sweep_left > 0) begin
        m_sweep_left--;
      end else if (upd_valid) begin
        s = pc_set(upd_pc);
        t = pc_tag(upd_pc);
        w = find_way(s, t);
        if (w >= 0) begin
          if (upd_taken) begin
            mctr[s][w] = (mctr[s][w] < 3) ? mctr[s][w] + 1 : 3;
            mtgt[s][w] = upd_target;
          end else begin
            mctr[s][w] = (mctr[s][w] > 0) ? mctr[s][w] - 1 : 0;
          end
        end else if (upd_taken) begin
          w = mrr[s];
          mv[s][w]   = 1'b1;
          mtag[s][w] = t;
          mtgt[s][w] = upd_target;
          mctr[s][w] = 2;
          mrr[s]     = (mrr[s] + 1) % NW;
        end
      end
    end
    #1;
    if (m_known) begin
      check("model_ready", {31'd0, ready}, {31'd0, m_sweep_left == 0});
      check("model_resp_valid", {31'd0, resp_valid}, {31'd0, e_rv});
      check("model_resp_hit", {31'd0, resp_hit}, {31'd0, e_hit});
      check("model_resp_taken", {31'd0, resp_taken}, {31'd0, e_tk});
      check("model_resp_target", resp_target, e_tg);
    end
  end

  task automatic cyc(input bit rq, input logic [31:0] rpc, input bit uv, input logic [31:0] upc,
                     input bit ut, input logic [31:0] utg, input bit fl, input bit rs);
    @(negedge clk);
    req_valid = rq; req_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    flush = fl; rst = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, '0, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1, pc, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    cyc(0, '0, 1, pc, tk, tg, 0, 0);
  endtask

  task automatic expect_resp(input string name, input bit v, input bit h, input bit tk, input logic [31:0] tg);
    check({name, "_valid"}, {31'd0, resp_valid}, {31'd0, v});
    check({name, "_hit"}, {31'd0, resp_hit}, {31'd0, h});
    check({name, "_taken"}, {31'd0, resp_taken}, {31'd0, tk});
    check({name, "_target"}, resp_target, tg);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      idle();
      n++;
    end
    check(name, n, 64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and initial sweep
    cyc(0, '0, 0, '0, 0, '0, 0, 1);
    expect_resp("reset", 0, 0, 0, 32'h0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    wait_ready("sweep_len_after_reset");
    look(32'h1000);
    expect_resp("empty_lookup", 1, 0, 0, 32'h0);

    // Allocate and hit, low PC bits ignored
    upd(32'h1004, 1, 32'h2000);
    look(32'h1004);
    expect_resp("alloc_hit", 1, 1, 1, 32'h2000);
    look(32'h1006);
    expect_resp("lowbits_hit", 1, 1, 1, 32'h2000);

    // Counter saturation at both ends
    upd(32'h1004, 0, 32'h0);
    look(32'h1004);
    expect_resp("ctr1", 1, 1, 0, 32'h2000);
    upd(32'h1004, 0, 32'h0);
    upd(32'h1004, 0, 32'h0);
    look(32'h1004);
    expect_resp("ctr0_sat", 1, 1, 0, 32'h2000);
    for (int k = 1; k <= 4; k++) upd(32'h1004, 1, 32'h2000 + 32'(k) * 32'h100);
    look(32'h1004);
    expect_resp("ctr3_sat", 1, 1, 1, 32'h2400);
    upd(32'h1004, 0, 32'h0);
    look(32'h1004);
    expect_resp("ctr3_dec", 1, 1, 1, 32'h2400);
    upd(32'h1004, 0, 32'h0);
    look(32'h1004);
    expect_resp("ctr1_again", 1, 1, 0, 32'h2400);

    // Round-robin eviction in set 1
    for (int k = 0; k < 5; k++) upd(32'h0004 + 32'(k) * 32'h100, 1, 32'h5000 + 32'(k));
    look(32'h0004);
    expect_resp("rr_evicted", 1, 0, 0, 32'h0);
    for (int k = 1; k < 5; k++) begin
      look(32'h0004 + 32'(k) * 32'h100);
      expect_resp("rr_kept", 1, 1, 1, 32'h5000 + 32'(k));
    end
    upd(32'h0504, 0, 32'h9999);
    look(32'h0504);
    expect_resp("nt_miss_noalloc", 1, 0, 0, 32'h0);
    look(32'h0104);
    expect_resp("nt_miss_keeps_k1", 1, 1, 1, 32'h5001);

    // Read-before-write
    cyc(1, 32'h3008, 1, 32'h3008, 1, 32'h4000, 0, 0);
    expect_resp("rbw_same_cycle", 1, 0, 0, 32'h0);
    look(32'h3008);
    expect_resp("rbw_next_cycle", 1, 1, 1, 32'h4000);

    // Flush with update and lookup in the same cycle
    cyc(1, 32'h3008, 1, 32'h700C, 1, 32'h7777, 1, 0);
    expect_resp("flush_cycle_resp", 1, 1, 1, 32'h4000);
    wait_ready("sweep_len_after_flush");
    look(32'h700C);
    expect_resp("flush_drops_update", 1, 0, 0, 32'h0);
    look(32'h3008);
    expect_resp("flush_clears_3008", 1, 0, 0, 32'h0);
    look(32'h0104);
    expect_resp("flush_clears_0104", 1, 0, 0, 32'h0);

    // Lookup dropped during sweep, reset restarts the sweep
    cyc(0, '0, 0, '0, 0, '0, 1, 0);
    for (int k = 0; k < 5; k++) idle();
    look(32'h1000);
    expect_resp("sweep_drop", 0, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) idle();
    cyc(0, '0, 0, '0, 0, '0, 0, 1);
    wait_ready("sweep_len_rst_restart");
    upd(32'h2010, 1, 32'hABCD);
    look(32'h2010);
    expect_resp("final_hit", 1, 1, 1, 32'hABCD);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btb_sa_ctr.md
Name: btb_sa_ctr

Overview:
- Parametrised next-generation branch target buffer for the IF1 stage: set-associative, tagged, with a 2-bit taken counter per entry.
- Lookup is registered: a request in cycle N returns hit/target/taken-prediction in cycle N+1.
- The EX stage writes through an update port that refreshes an existing entry or allocates a new one (round-robin per set).
- A sweep state machine clears all entries after reset and on an explicit flush.

Parameters:
- NUM_SETS, 64, number of sets; power of two, >=2; INDEX_BITS = log2(NUM_SETS)
- NUM_WAYS, 4, ways per set; power of two, >=1; WAY_BITS = max(1, log2(NUM_WAYS))
- TAG_BITS, 8, tag width; INDEX_BITS + TAG_BITS + 2 <= 32 is required
- TARGET_BITS, 32, stored target width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  one-cycle pulse: invalidate all entries
- ready  out  1  1 = idle; lookups and updates accepted
- req_valid  in  1  lookup request
- req_pc  in  32  lookup PC (IF1)
- resp_valid  out  1  response valid, one cycle after an accepted request
- resp_hit  out  1  tag match in the looked-up set
- resp_taken  out  1  resp_hit && counter[1]
- resp_target  out  TARGET_BITS  target of the hit entry; 0 on miss
- upd_valid  in  1  update from EX
- upd_pc  in  32  branch PC
- upd_taken  in  1  resolved direction
- upd_target  in  TARGET_BITS  resolved target

Behaviour:
- Field split: index = pc[INDEX_BITS+1:2]; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]; pc[1:0] are ignored.
- Entry contents: valid, tag, target, ctr[1:0]. Each set has a round-robin pointer rr[WAY_BITS-1:0].
- Reset: all outputs are 0. The FSM enters SWEEP with sweep_idx = 0, so ready = 0.
- FSM states are SWEEP and IDLE.
  - SWEEP: each cycle clears valid and ctr of every way in set sweep_idx, sets rr = 0, then increments sweep_idx.
  - When sweep_idx = NUM_SETS-1 is cleared, the next state is IDLE. SWEEP lasts exactly NUM_SETS cycles.
  - IDLE + flush → SWEEP with sweep_idx = 0.
  - flush during SWEEP restarts the sweep at 0.
  - rst in any state → SWEEP at 0. rst has priority over flush.
- Lookup:
  - Accepted when req_valid && ready.
  - The next cycle drives resp_valid = 1 and resp_hit = OR over the ways of (valid && tag match). resp_target and resp_taken come from the matching way.
  - Multiple matches: the lowest way wins (they cannot occur by construction).
  - resp_valid is 0 in the cycle after a non-accepted or absent request. In that cycle resp_hit, resp_taken and resp_target are all 0.
  - Lookups present during SWEEP are dropped: no response is generated.
- Update (only when upd_valid && ready), on the next clock edge:
  - Hit in set: ctr saturating +1 if upd_taken, else saturating -1 (range 0..3). If upd_taken, target <= upd_target. rr is unchanged.
  - Miss && upd_taken: write way rr with valid = 1, tag, target, and ctr = 2'b10; then rr <= rr+1 mod NUM_WAYS.
  - Miss && !upd_taken: no change.
- Same-cycle lookup and update to the same set: the lookup returns the contents from before the update (read-before-write). The update is visible to lookups from the following cycle.
- flush and upd_valid in the same cycle: the update is dropped and the flush wins.
- A request accepted in the last IDLE cycle before a flush still gets its response in the next cycle.
- NUM_WAYS = 1: rr stays 0; every taken miss overwrites the single way.

Test Plan:
- Reset and sweep: assert rst for 1 cycle, deassert → ready = 0 for exactly 64 cycles, then 1. A lookup of 0x1000 gives resp_valid = 1, resp_hit = 0, resp_target = 0.
- Allocate and hit: update pc = 0x0000_1004, taken, target = 0x2000, then look up 0x1004 → next cycle resp_hit = 1, resp_taken = 1 (ctr = 2), resp_target = 0x2000. A lookup of 0x1006 gives the same result (low bits ignored).
- Counter saturation: two not-taken updates on 0x1004 → ctr = 0, resp_hit = 1, resp_taken = 0. A further not-taken update keeps ctr = 0. Four taken updates → ctr = 3, and target changes to the last upd_target.
- Round-robin eviction: five taken updates to distinct tags in set 1 (pc = 0x0004 + k*0x100, k = 0..4) → the first tag misses and tags k = 1..4 hit. A not-taken miss allocates nothing.
- Read-before-write: in the same cycle, lookup 0x3008 and a taken update 0x3008 → 0x4000; the response is hit = 0. A lookup the next cycle returns hit = 1 with target 0x4000.
- Flush mid-operation: flush together with upd_valid, then retry the lookup → the update is dropped, ready = 0 for 64 cycles, and all previous entries miss afterwards. Asserting rst during the sweep restarts the 64-cycle count.
